ycbcr2rgb: RTL and testbench

Pipelined YCbCr to RGB colour-space converter (JFIF full-range, 8.8 fixed point). It is the decode-side counterpart of the encoder's RGB to YCbCr stage and sits after the IDCT/upsampler in the JPEG decode path. Streaming valid/ready on both sides; sustains 1 pixel/clock; full backpressure support.

---
 rtl/ycbcr2rgb_if.sv | 33 +++
 rtl/ycbcr2rgb.sv | 188 ++++++++++++++++++
 tb/tb_ycbcr2rgb.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ycbcr2rgb_if.sv
// ycbcr2rgb_if -- streaming bus for the YCbCr to RGB converter.
//   Input side : in_valid/in_ready handshake, in_y/in_cb/in_cr pixel, in_last sideband.
//   Output side: out_valid/out_ready handshake, out_r/out_g/out_b pixel, out_last sideband,
//                pix_cnt (pixels transferred out since reset or the last out_last).
//   modport master : the pixel source / sink environment (drives in_*, out_ready).
//   modport slave  : the converter itself.
interface ycbcr2rgb_if #(
  parameter int CNT_W = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_y;
  logic [7:0]       in_cb;
  logic [7:0]       in_cr;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_r;
  logic [7:0]       out_g;
  logic [7:0]       out_b;
  logic             out_last;
  logic [CNT_W-1:0] pix_cnt;

  modport master (
    output in_valid, in_y, in_cb, in_cr, in_last, out_ready,
    input  in_ready, out_valid, out_r, out_g, out_b, out_last, pix_cnt
  );

  modport slave (
    input  in_valid, in_y, in_cb, in_cr, in_last, out_ready,
    output in_ready, out_valid, out_r, out_g, out_b, out_last, pix_cnt
  );
endinterface

// File: rtl/ycbcr2rgb.sv
// ycbcr2rgb -- three-stage pipelined JFIF full-range YCbCr to RGB converter,
// 8.8 fixed point, one pixel per clock, full valid/ready backpressure.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   io     : ycbcr2rgb_if.slave (input stream, output stream, pix_cnt)
// Parameters:
//   CNT_W  : width of pix_cnt (must match the interface instance)
// Build option:
//   YCC2RGB_ROUND_EN : when defined, each product gets +128 before the >>> 8
//                      (round half up); otherwise pure floor truncation.
// Pipeline: S1 offsets chroma, S2 forms the products, S3 shifts/adds/clamps
// into the output registers. All stages advance together unless the output
// holds an unaccepted pixel, so in_ready is combinational from out_ready.
module ycbcr2rgb #(
  parameter int CNT_W = 16
) (
  input logic      clk,
  input logic      rst_n,
  ycbcr2rgb_if.slave io
);

  localparam logic signed [17:0] K_R_CR = 18'sd359;
  localparam logic signed [17:0] K_G_CB = -18'sd88;
  localparam logic signed [17:0] K_G_CR = -18'sd183;
  localparam logic signed [17:0] K_B_CB = 18'sd454;

  // Shift a product down to an integer offset, add luma and saturate to 0..255.
  function automatic logic [7:0] add_clamp(input logic [7:0] y, input logic signed [17:0] prod);
    logic signed [17:0] p_adj;
    logic signed [17:0] t;
    logic signed [17:0] sum;
`ifdef YCC2RGB_ROUND_EN
    p_adj = prod + 18'sd128;
`else
    p_adj = prod;
`endif
    t   = p_adj >>> 8;
    sum = $signed({10'd0, y}) + t;
    if (sum < 18'sd0) begin
      add_clamp = 8'd0;
    end else if (sum > 18'sd255) begin
      add_clamp = 8'd255;
    end else begin
      add_clamp = sum[7:0];
    end
  endfunction

  logic stall;
  logic adv;

  // S1
  logic              s1_valid_q, s1_valid_d;
  logic [7:0]        s1_y_q, s1_y_d;
  logic signed [8:0] s1_cb_q, s1_cb_d;
  logic signed [8:0] s1_cr_q, s1_cr_d;
  logic              s1_last_q, s1_last_d;

  // S2
  logic               s2_valid_q, s2_valid_d;
  logic [7:0]         s2_y_q, s2_y_d;
  logic signed [17:0] s2_pr_q, s2_pr_d;
  logic signed [17:0] s2_pg_q, s2_pg_d;
  logic signed [17:0] s2_pb_q, s2_pb_d;
  logic               s2_last_q, s2_last_d;

  // S3 / output registers
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_r_q, out_r_d;
  logic [7:0]       out_g_q, out_g_d;
  logic [7:0]       out_b_q, out_b_d;
  logic             out_last_q, out_last_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;

  logic signed [17:0] cb_ext;
  logic signed [17:0] cr_ext;

  assign stall = out_valid_q && !io.out_ready;
  assign adv   = !stall;

  assign cb_ext = {{9{s1_cb_q[8]}}, s1_cb_q};
  assign cr_ext = {{9{s1_cr_q[8]}}, s1_cr_q};

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_y_d      = s1_y_q;
    s1_cb_d     = s1_cb_q;
    s1_cr_d     = s1_cr_q;
    s1_last_d   = s1_last_q;
    s2_valid_d  = s2_valid_q;
    s2_y_d      = s2_y_q;
    s2_pr_d     = s2_pr_q;
    s2_pg_d     = s2_pg_q;
    s2_pb_d     = s2_pb_q;
    s2_last_d   = s2_last_q;
    out_valid_d = out_valid_q;
    out_r_d     = out_r_q;
    out_g_d     = out_g_q;
    out_b_d     = out_b_q;
    out_last_d  = out_last_q;
    pix_cnt_d   = pix_cnt_q;

    if (adv) begin
      // Bubbles travel as invalid stages; data only loads with a real pixel.
      s1_valid_d = io.in_valid;
      if (io.in_valid) begin
        s1_y_d    = io.in_y;
        s1_cb_d   = $signed({1'b0, io.in_cb}) - 9'sd128;
        s1_cr_d   = $signed({1'b0, io.in_cr}) - 9'sd128;
        s1_last_d = io.in_last;
      end

      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_y_d    = s1_y_q;
        s2_pr_d   = K_R_CR * cr_ext;
        s2_pg_d   = (K_G_CB * cb_ext) + (K_G_CR * cr_ext);
        s2_pb_d   = K_B_CB * cb_ext;
        s2_last_d = s1_last_q;
      end

      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        out_r_d    = add_clamp(s2_y_q, s2_pr_q);
        out_g_d    = add_clamp(s2_y_q, s2_pg_q);
        out_b_d    = add_clamp(s2_y_q, s2_pb_q);
        out_last_d = s2_last_q;
      end
    end

    // A transferred last pixel restarts the count rather than incrementing it.
    if (out_valid_q && io.out_ready) begin
      if (out_last_q) begin
        pix_cnt_d = '0;
      end else begin
        pix_cnt_d = pix_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_y_q      <= '0;
      s1_cb_q     <= '0;
      s1_cr_q     <= '0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_y_q      <= '0;
      s2_pr_q     <= '0;
      s2_pg_q     <= '0;
      s2_pb_q     <= '0;
      s2_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_g_q     <= '0;
      out_b_q     <= '0;
      out_last_q  <= 1'b0;
      pix_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_y_q      <= s1_y_d;
      s1_cb_q     <= s1_cb_d;
      s1_cr_q     <= s1_cr_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_y_q      <= s2_y_d;
      s2_pr_q     <= s2_pr_d;
      s2_pg_q     <= s2_pg_d;
      s2_pb_q     <= s2_pb_d;
      s2_last_q   <= s2_last_d;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_g_q     <= out_g_d;
      out_b_q     <= out_b_d;
      out_last_q  <= out_last_d;
      pix_cnt_q   <= pix_cnt_d;
    end
  end

  assign io.in_ready  = adv;
  assign io.out_valid = out_valid_q;
  assign io.out_r     = out_r_q;
  assign io.out_g     = out_g_q;
  assign io.out_b     = out_b_q;
  assign io.out_last  = out_last_q;
  assign io.pix_cnt   = pix_cnt_q;

endmodule

// File: tb/tb_ycbcr2rgb.sv
// tb_ycbcr2rgb -- self-checking bench for ycbcr2rgb against an integer
// arithmetic reference of the JFIF conversion.
module tb_ycbcr2rgb;
  localparam int CNT_W = 16;
  localparam int N_RAND = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  ycbcr2rgb_if #(.CNT_W(CNT_W)) bus ();
  ycbcr2rgb #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .io(bus));

  always #5 clk = ~clk;

  // Floor division by 256 on plain integers.
  function automatic int floor256(input int a);
    if (a >= 0) return a / 256;
    return -((-a + 255) / 256);
  endfunction

  function automatic int scale(input int prod);
`ifdef YCC2RGB_ROUND_EN
    return floor256(prod + 128);
`else
    return floor256(prod);
`endif
  endfunction

  function automatic int sat(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  function automatic logic [23:0] ref_rgb(input int y, input int cb, input int cr);
    int dcb, dcr, r, g, b;
    dcb = cb - 128;
    dcr = cr - 128;
    r = sat(y + scale(359 * dcr));
    g = sat(y + scale(-88 * dcb - 183 * dcr));
    b = sat(y + scale(454 * dcb));
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_y     = 8'd0;
    bus.in_cb    = 8'd0;
    bus.in_cr    = 8'd0;
    bus.in_last  = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_cnt = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0h want=0", bus.out_valid); end
    total++;
    if ({bus.out_r, bus.out_g, bus.out_b} !== 24'h0) begin
      bad++; $display("FAIL reset_rgb got=%06h want=000000", {bus.out_r, bus.out_g, bus.out_b});
    end
    total++;
    if (bus.out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%0h want=0", bus.out_last); end
    total++;
    if (bus.pix_cnt !== '0) begin bad++; $display("FAIL reset_pix_cnt got=%0d want=0", bus.pix_cnt); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0h want=1", bus.in_ready); end
    @(posedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_valid got=%0h want=0", bus.out_valid); end
    exp_cnt = '0;
  endtask

  // Sends one pixel into an idle pipe and reports what came out; no checking here.
  task automatic send_one(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                          output logic [23:0] rgb, output int lat,
                          output logic valid_after, output logic [CNT_W-1:0] cnt_after);
    bus.in_valid  = 1'b1;
    bus.in_y      = y;
    bus.in_cb     = cb;
    bus.in_cr     = cr;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    idle_inputs();
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rgb = {bus.out_r, bus.out_g, bus.out_b};
    @(posedge clk);
    #1;
    valid_after = bus.out_valid;
    cnt_after   = bus.pix_cnt;
  endtask

  task automatic test_directed();
    logic [23:0] vec [4];
    logic [23:0] rgb, want;
    logic [7:0] y, cb, cr;
    int lat;
    logic va;
    logic [CNT_W-1:0] cnt;
    vec[0] = {8'd128, 8'd128, 8'd128};
    vec[1] = {8'd0,   8'd0,   8'd0};
    vec[2] = {8'd255, 8'd128, 8'd255};
    vec[3] = {8'd81,  8'd90,  8'd240};
    for (int i = 0; i < 4; i++) begin
      y  = vec[i][23:16];
      cb = vec[i][15:8];
      cr = vec[i][7:0];
      want = ref_rgb(int'(y), int'(cb), int'(cr));
      send_one(y, cb, cr, rgb, lat, va, cnt);
      exp_cnt = exp_cnt + CNT_W'(1);
      total++;
      if (lat != 3) begin bad++; $display("FAIL dir%0d_latency got=%0d want=3", i, lat); end
      total++;
      if (rgb !== want) begin bad++; $display("FAIL dir%0d_rgb got=%06h want=%06h", i, rgb, want); end
      total++;
      if (va !== 1'b0) begin bad++; $display("FAIL dir%0d_single_valid got=%0h want=0", i, va); end
      total++;
      if (cnt !== exp_cnt) begin bad++; $display("FAIL dir%0d_pix_cnt got=%0d want=%0d", i, cnt, exp_cnt); end
    end
    // Hand-derived anchors for the clamped cases.
    want = ref_rgb(0, 0, 0);
    total++;
    if (want[23:16] !== 8'd0 || want[7:0] !== 8'd0) begin bad++; $display("FAIL model_low_clamp got=%06h want=00xx00", want); end
    want = ref_rgb(255, 128, 255);
    total++;
    if (want !== {8'd255, 8'd164, 8'd255}) begin bad++; $display("FAIL model_high_clamp got=%06h want=ffa4ff", want); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] pix [8];
    logic [23:0] want, got;
    logic exp_valid;
    int k, n;
    logic [CNT_W-1:0] want_cnt;
    apply_reset();
    for (int i = 0; i < 8; i++) pix[i] = 24'($urandom);
    for (int c = 0; c < 12; c++) begin
      bus.out_ready = 1'b1;
      if (c < 8) begin
        bus.in_valid = 1'b1;
        bus.in_y     = pix[c][23:16];
        bus.in_cb    = pix[c][15:8];
        bus.in_cr    = pix[c][7:0];
        bus.in_last  = (c == 7);
      end else begin
        idle_inputs();
      end
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready c=%0d got=%0h want=1", c, bus.in_ready); end
      @(posedge clk);
      #1;
      // pixel k is accepted on edge k+1 and shows on the output after edge k+3
      k = c - 2;
      exp_valid = (k >= 0 && k < 8);
      total++;
      if (bus.out_valid !== exp_valid) begin bad++; $display("FAIL b2b_valid c=%0d got=%0h want=%0h", c, bus.out_valid, exp_valid); end
      if (exp_valid) begin
        want = ref_rgb(int'(pix[k][23:16]), int'(pix[k][15:8]), int'(pix[k][7:0]));
        got  = {bus.out_r, bus.out_g, bus.out_b};
        total++;
        if (got !== want) begin bad++; $display("FAIL b2b_rgb k=%0d got=%06h want=%06h", k, got, want); end
        total++;
        if (bus.out_last !== (k == 7)) begin bad++; $display("FAIL b2b_last k=%0d got=%0h want=%0h", k, bus.out_last, (k == 7)); end
      end
      n = c - 2;
      if (n < 0) n = 0;
      if (n > 8) n = 8;
      want_cnt = (n == 8) ? '0 : CNT_W'(n);
      total++;
      if (bus.pix_cnt !== want_cnt) begin bad++; $display("FAIL b2b_pix_cnt c=%0d got=%0d want=%0d", c, bus.pix_cnt, want_cnt); end
    end
    exp_cnt = '0;
  endtask

  task automatic test_backpressure();
    logic [24:0] sb [$];
    logic [24:0] exp_item, hold_val, cur;
    logic hold_pend;
    int sent, got, cyc;
    logic [7:0] y, cb, cr;
    logic lst;
    sent = 0; got = 0; cyc = 0; hold_pend = 1'b0; hold_val = '0;
    while ((sent < N_RAND || sb.size() != 0) && cyc < 20000) begin
      cur = {bus.out_last, bus.out_r, bus.out_g, bus.out_b};
      if (hold_pend) begin
        total++;
        if (bus.out_valid !== 1'b1 || cur !== hold_val) begin
          bad++; $display("FAIL bp_stable cyc=%0d got=%0h/%07h want=1/%07h", cyc, bus.out_valid, cur, hold_val);
        end
      end
      y = 8'($urandom); cb = 8'($urandom); cr = 8'($urandom);
      lst = ($urandom_range(0, 7) == 0);
      bus.in_y = y; bus.in_cb = cb; bus.in_cr = cr; bus.in_last = lst;
      bus.in_valid = (sent < N_RAND) && ($urandom_range(0, 3) != 0);
      if (cyc >= 30 && cyc < 35) bus.out_ready = 1'b0;
      else bus.out_ready = ($urandom_range(0, 9) < 7);
      #1;
      total++;
      if (bus.in_ready !== !(bus.out_valid && !bus.out_ready)) begin
        bad++; $display("FAIL bp_in_ready cyc=%0d got=%0h want=%0h", cyc, bus.in_ready, !(bus.out_valid && !bus.out_ready));
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back({lst, ref_rgb(int'(y), int'(cb), int'(cr))});
        sent++;
      end
      hold_pend = bus.out_valid && !bus.out_ready;
      hold_val  = {bus.out_last, bus.out_r, bus.out_g, bus.out_b};
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL bp_extra_pixel cyc=%0d got=%07h want=none", cyc, hold_val);
        end else begin
          exp_item = sb.pop_front();
          got++;
          if (hold_val !== exp_item) begin
            bad++; $display("FAIL bp_pixel n=%0d got=%07h want=%07h", got, hold_val, exp_item);
          end
          exp_cnt = exp_item[24] ? '0 : exp_cnt + CNT_W'(1);
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      total++;
      if (bus.pix_cnt !== exp_cnt) begin bad++; $display("FAIL bp_pix_cnt cyc=%0d got=%0d want=%0d", cyc, bus.pix_cnt, exp_cnt); end
    end
    total++;
    if (cyc >= 20000) begin bad++; $display("FAIL bp_timeout got=%0d want<20000", cyc); end
    total++;
    if (got != N_RAND) begin bad++; $display("FAIL bp_count got=%0d want=%0d", got, N_RAND); end
    idle_inputs();
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_y  = 8'($urandom);
      bus.in_cb = 8'($urandom);
      bus.in_cr = 8'($urandom);
      bus.in_last = (i == 2);
      @(posedge clk);
      #1;
    end
    idle_inputs();
    total++;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL mid_inflight got=%0h want=1", bus.out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%0h want=0", bus.out_valid); end
    total++;
    if ({bus.out_last, bus.out_r, bus.out_g, bus.out_b} !== 25'h0) begin
      bad++; $display("FAIL mid_rst_outputs got=%07h want=0", {bus.out_last, bus.out_r, bus.out_g, bus.out_b});
    end
    total++;
    if (bus.pix_cnt !== '0) begin bad++; $display("FAIL mid_rst_pix_cnt got=%0d want=0", bus.pix_cnt); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    exp_cnt = '0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%0h want=1", bus.in_ready); end
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      total++;
      if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_stale c=%0d got=%0h want=0", c, bus.out_valid); end
      total++;
      if (bus.pix_cnt !== '0) begin bad++; $display("FAIL mid_pix_cnt c=%0d got=%0d want=0", c, bus.pix_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
